dmem_arbiter: RTL and testbench

- Shares the single-port data memory of the pipelined MIPS core between two requesters: the pipeline MEM stage (cpu) and a debug/test loader (dbg).
- Uses a two-way round-robin arbiter and a fixed-latency access sequencer.
- Stalls the pipeline while a cpu access is pending.
- Sits between the MEM stage / loader and the dmem instance inside top.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: sequencer states,
// requester indices and the latency counter width.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DBG = 1;
  localparam int unsigned LAT_W   = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Holds which requester was granted last and
// favours the other one on a tie; reset leaves cpu favoured.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_dbg;

  always_comb begin
    gnt = '0;
    if (req[REQ_CPU] && (!req[REQ_DBG] || last_dbg)) begin
      gnt[REQ_CPU] = 1'b1;
    end else if (req[REQ_DBG]) begin
      gnt[REQ_DBG] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dbg <= 1'b1;
    end else if (update && (|gnt)) begin
      last_dbg <= gnt[REQ_DBG];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (cpu) and the
// debug loader (dbg) with round-robin grant and a fixed-latency sequencer.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_done,
  output logic          dbg_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t             state, state_nx;
  logic [1:0]         arb_req, gnt, win_q;
  logic               we_q, err_q;
  logic [LAT_W-1:0]   cnt;
  logic               sel_dbg, sel_we, sel_mis;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  // In RESP the picker sees only the latched winner, so the pointer records
  // the access actually served even if its req was dropped early.
  assign arb_req = (state == RESP) ? win_q : {dbg_req, cpu_req};

  rr_arb2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .update (state == RESP),
    .gnt    (gnt)
  );

  assign sel_dbg   = gnt[REQ_DBG];
  assign sel_we    = sel_dbg ? dbg_we    : cpu_we;
  assign sel_addr  = sel_dbg ? dbg_addr  : cpu_addr;
  assign sel_wdata = sel_dbg ? dbg_wdata : cpu_wdata;
  assign sel_mis   = |sel_addr[1:0];

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|gnt) state_nx = sel_mis ? RESP : ACCESS;
      ACCESS:  state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      dbg_done  <= 1'b0;
      dbg_err   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      dbg_done <= 1'b0;
      dbg_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            win_q     <= gnt;
            we_q      <= sel_we;
            err_q     <= sel_mis;
            mem_addr  <= sel_addr[AW-1:2];
            mem_wdata <= sel_wdata;
          end
        end
        ACCESS: cnt <= LAT_W'(MEM_LAT - 1);
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!we_q) begin
            if (win_q[REQ_DBG]) dbg_rdata <= mem_rdata;
            else                cpu_rdata <= mem_rdata;
          end
        end
        RESP: begin
          cpu_done <= win_q[REQ_CPU];
          cpu_err  <= win_q[REQ_CPU] & err_q;
          dbg_done <= win_q[REQ_DBG];
          dbg_err  <= win_q[REQ_DBG] & err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (MEM_LAT=1 and 3), each with
// its own fixed-latency memory model, checked against hand-computed values.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req [2], cpu_we [2], dbg_req [2], dbg_we [2];
  logic [31:0] cpu_addr [2], cpu_wdata [2], dbg_addr [2], dbg_wdata [2];
  logic [31:0] cpu_rdata [2], dbg_rdata [2], mem_wdata [2];
  logic        cpu_done [2], cpu_err [2], cpu_stall [2];
  logic        dbg_done [2], dbg_err [2], mem_en [2], mem_we [2];
  logic [29:0] mem_addr [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [31:0] mem [0:63];
    logic [31:0] pipe [0:L];
    logic [31:0] rdata_m;
    bit          primed = 1'b0;
    int          en_cnt = 0, cyc = 0, log_n = 0, n_cdone = 0;
    bit          dbl = 1'b0, both = 1'b0, en_prev = 1'b0;
    bit          log_who [0:63];
    int          log_cyc [0:63];

    assign rdata_m = pipe[L];

    dmem_arbiter #(.DW(32), .AW(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_done(cpu_done[g]),
      .cpu_err(cpu_err[g]), .cpu_stall(cpu_stall[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_rdata(dbg_rdata[g]), .dbg_done(dbg_done[g]),
      .dbg_err(dbg_err[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(rdata_m)
    );

    // Memory and monitor run on the falling edge to stay clear of the DUT edge;
    // read data is only meaningful in the single cycle the DUT should sample it.
    always @(negedge clk) begin
      if (!primed) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hD000_0000 + i;
        mem[21] <= 32'd7;
        for (int i = 0; i <= int'(L); i++) pipe[i] <= 32'hBAD0_BAD0;
        primed <= 1'b1;
      end else begin
        if (mem_en[g] && mem_we[g]) mem[mem_addr[g][5:0]] <= mem_wdata[g];
        pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][5:0]] : 32'hBAD0_BAD0;
        for (int i = 1; i <= int'(L); i++) pipe[i] <= pipe[i-1];
      end
      cyc     <= cyc + 1;
      en_prev <= mem_en[g];
      if (mem_en[g]) en_cnt <= en_cnt + 1;
      if (mem_en[g] && en_prev) dbl <= 1'b1;
      if (cpu_done[g] && dbg_done[g]) both <= 1'b1;
      if (cpu_done[g]) n_cdone <= n_cdone + 1;
      if ((cpu_done[g] || dbg_done[g]) && log_n < 64) begin
        log_who[log_n] <= dbg_done[g];
        log_cyc[log_n] <= cyc;
        log_n          <= log_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from just after an edge; k is the edge index (0 = the
  // sampling edge) at which done rose, 99 on timeout.
  task automatic do_req(input int d, input bit dbg, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd, input bit keep,
                        output int k, output bit en0, output bit we0,
                        output logic [29:0] a0, output logic [31:0] w0,
                        output bit err, output bit stall_ok);
    bit done = 1'b0;
    if (dbg) begin
      dbg_req[d] = 1'b1; dbg_we[d] = we; dbg_addr[d] = addr; dbg_wdata[d] = wd;
    end else begin
      cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wd;
    end
    k = -1; stall_ok = 1'b1; en0 = 1'b0; we0 = 1'b0; a0 = '0; w0 = '0;
    while (!done && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 0) begin
        en0 = mem_en[d]; we0 = mem_we[d]; a0 = mem_addr[d]; w0 = mem_wdata[d];
      end
      done = dbg ? dbg_done[d] : cpu_done[d];
      if (!dbg && (cpu_stall[d] == done)) stall_ok = 1'b0;
    end
    err = dbg ? dbg_err[d] : cpu_err[d];
    if (!done) k = 99;
    if (!keep) begin
      if (dbg) dbg_req[d] = 1'b0;
      else     cpu_req[d] = 1'b0;
    end
  endtask

  initial begin
    int k, b0, b1, snap;
    bit en0, we0, err, sok;
    logic [29:0] a0;
    logic [31:0] w0;

    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 0; cpu_we[d] = 0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      dbg_req[d] = 0; dbg_we[d] = 0; dbg_addr[d] = '0; dbg_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cpu_done", 64'(cpu_done[d]), 0);
      chk("rst_dbg_done", 64'(dbg_done[d]), 0);
      chk("rst_errs",     64'({cpu_err[d], dbg_err[d]}), 0);
      chk("rst_mem_en",   64'({mem_en[d], mem_we[d]}), 0);
      chk("rst_mem_addr", 64'(mem_addr[d]), 0);
      chk("rst_mem_wdata", 64'(mem_wdata[d]), 0);
      chk("rst_rdata",    64'({cpu_rdata[d], dbg_rdata[d]}), 0);
      chk("rst_stall",    64'(cpu_stall[d]), 0);
    end
    reset = 1'b1;

    // reset pulled during WAIT on the MEM_LAT=3 instance
    sync();
    snap = g_dut[1].n_cdone;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'd84;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_in_wait", 64'(g_dut[1].u_dut.state), 64'(WAIT));
    reset = 1'b0;
    #1;
    chk("midrst_state", 64'(g_dut[1].u_dut.state), 64'(IDLE));
    chk("midrst_mem_en", 64'(mem_en[1]), 0);
    cpu_req[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(g_dut[1].n_cdone), 64'(snap));
    chk("midrst_rdata", 64'(cpu_rdata[1]), 0);

    // cpu load after reset, MEM_LAT=3
    do_req(1, 0, 0, 32'd84, 32'd0, 0, k, en0, we0, a0, w0, err, sok);
    chk("load3_lat", 64'(k), 5);
    chk("load3_rdata", 64'(cpu_rdata[1]), 7);
    chk("load3_access", 64'({en0, we0, a0}), 64'({1'b1, 1'b0, 30'd21}));
    chk("load3_err", 64'(err), 0);
    chk("load3_stall", 64'(sok), 1);

    // cpu store, MEM_LAT=1
    sync();
    do_req(0, 0, 1, 32'd84, 32'hFFFF_FFFB, 0, k, en0, we0, a0, w0, err, sok);
    chk("store1_lat", 64'(k), 3);
    chk("store1_access", 64'({en0, we0, a0}), 64'({1'b1, 1'b1, 30'd21}));
    chk("store1_wdata", 64'(w0), 64'h0000_0000_FFFF_FFFB);
    chk("store1_stall", 64'(sok), 1);
    #1;
    chk("store1_stall_off", 64'(cpu_stall[0]), 0);
    chk("store1_rdata_kept", 64'(cpu_rdata[0]), 0);
    sync();
    do_req(0, 0, 0, 32'd84, 32'd0, 0, k, en0, we0, a0, w0, err, sok);
    chk("load1_lat", 64'(k), 3);
    chk("load1_rdata", 64'(cpu_rdata[0]), 64'h0000_0000_FFFF_FFFB);

    // dbg aligned load, then misaligned load leaves dbg_rdata alone
    sync();
    do_req(1, 1, 0, 32'd8, 32'd0, 0, k, en0, we0, a0, w0, err, sok);
    chk("dbgload_lat", 64'(k), 5);
    chk("dbgload_rdata", 64'(dbg_rdata[1]), 64'hD000_0002);
    sync();
    snap = g_dut[1].en_cnt;
    do_req(1, 1, 0, 32'h55, 32'd0, 0, k, en0, we0, a0, w0, err, sok);
    chk("mis_lat", 64'(k), 1);
    chk("mis_err", 64'(err), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mis_no_mem_en", 64'(g_dut[1].en_cnt), 64'(snap));
    chk("mis_rdata_kept", 64'(dbg_rdata[1]), 64'hD000_0002);

    // dbg back-to-back stores with req held, MEM_LAT=1
    sync();
    snap = g_dut[0].n_cdone;
    for (int i = 0; i < 3; i++) begin
      do_req(0, 1, 1, 32'(4 * i), 32'(11 * (i + 1)), (i < 2), k, en0, we0, a0, w0, err, sok);
      chk("b2b_lat", 64'(k), 3);
      chk("b2b_addr", 64'({en0, we0, a0}), 64'({1'b1, 1'b1, 30'(i)}));
    end
    chk("b2b_cpu_quiet", 64'(g_dut[0].n_cdone), 64'(snap));
    sync();
    do_req(0, 1, 0, 32'd4, 32'd0, 0, k, en0, we0, a0, w0, err, sok);
    chk("b2b_readback", 64'(dbg_rdata[0]), 22);

    // contention: both requesters held from reset on both instances
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b1; cpu_we[d] = 1'b0; cpu_addr[d] = 32'd84;
      dbg_req[d] = 1'b1; dbg_we[d] = 1'b0; dbg_addr[d] = 32'd12;
    end
    sync();
    b0 = g_dut[0].log_n;
    b1 = g_dut[1].log_n;
    reset = 1'b1;
    for (int c = 0; c < 120 && !(g_dut[0].log_n >= b0 + 4 && g_dut[1].log_n >= b1 + 4); c++)
      @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      cpu_req[d] = 1'b0; dbg_req[d] = 1'b0;
    end
    chk("cont_count0", 64'(g_dut[0].log_n >= b0 + 4), 1);
    chk("cont_count1", 64'(g_dut[1].log_n >= b1 + 4), 1);
    for (int i = 0; i < 4; i++) begin
      chk("cont_order0", 64'(g_dut[0].log_who[b0 + i]), 64'(i % 2));
      chk("cont_order1", 64'(g_dut[1].log_who[b1 + i]), 64'(i % 2));
    end
    for (int i = 1; i < 4; i++) begin
      chk("cont_space0", 64'(g_dut[0].log_cyc[b0 + i] - g_dut[0].log_cyc[b0 + i - 1]), 4);
      chk("cont_space1", 64'(g_dut[1].log_cyc[b1 + i] - g_dut[1].log_cyc[b1 + i - 1]), 6);
    end
    repeat (15) @(posedge clk);
    #1;
    chk("cont_cpu_rdata0", 64'(cpu_rdata[0]), 64'h0000_0000_FFFF_FFFB);
    chk("cont_cpu_rdata1", 64'(cpu_rdata[1]), 7);
    chk("cont_dbg_rdata0", 64'(dbg_rdata[0]), 64'hD000_0003);
    chk("cont_dbg_rdata1", 64'(dbg_rdata[1]), 64'hD000_0003);
    chk("no_double_en", 64'({g_dut[0].dbl, g_dut[1].dbl}), 0);
    chk("no_double_done", 64'({g_dut[0].both, g_dut[1].both}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
